// File: rtl/collatz_dispatch.sv
// collatz_dispatch: shares RAM_WORDS Collatz start values across NUM_ENGINES iterators and stores run lengths.
// Optional MAX_TRACK_EN macro adds max_count/max_n tracking of the largest stored result. Rev 1.0
`default_nettype none

module collatz_dispatch #(
  parameter int NUM_ENGINES   = 4,
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic [31:0]                start,
  output logic                       done,
  input  logic [RAM_ADDR_BITS-1:0]   rd_addr,
  output logic [15:0]                count,
  output logic [NUM_ENGINES-1:0]     eng_go,
  output logic [32*NUM_ENGINES-1:0]  eng_n,
  input  logic [NUM_ENGINES-1:0]     eng_done
`ifdef MAX_TRACK_EN
  ,
  output logic [15:0]                max_count,
  output logic [31:0]                max_n
`endif
);

  localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int CW = RAM_ADDR_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
  typedef enum logic [1:0] {E_FREE, E_BUSY, E_HOLD} eng_state_t;

  state_t                   state, state_next;
  eng_state_t               est    [NUM_ENGINES];
  logic [15:0]              cyc    [NUM_ENGINES];
  logic [15:0]              result [NUM_ENGINES];
  logic [RAM_ADDR_BITS-1:0] tag    [NUM_ENGINES];
  logic [15:0]              mem    [RAM_WORDS];
  logic [31:0]              base;
  logic [CW-1:0]            issued, written;
  logic                     start_sweep, finish;
  logic                     launch, wr_en;
  logic [IW-1:0]            launch_idx, wr_idx;

  always_comb begin
    state_next  = state;
    start_sweep = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE, S_FINISH: begin
        if (go) begin
          state_next  = S_RUN;
          start_sweep = 1'b1;
        end
      end
      S_RUN: begin
        if (written == CW'(RAM_WORDS)) begin
          state_next = S_FINISH;
          finish     = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Descending scan so the lowest matching index wins both arbiters.
  always_comb begin
    launch     = 1'b0;
    launch_idx = '0;
    wr_en      = 1'b0;
    wr_idx     = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (est[i] == E_FREE) begin
        launch     = 1'b1;
        launch_idx = IW'(i);
      end
      if (est[i] == E_HOLD) begin
        wr_en  = 1'b1;
        wr_idx = IW'(i);
      end
    end
    launch = launch && (state == S_RUN) && (issued < CW'(RAM_WORDS));
    wr_en  = wr_en && (state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      eng_go  <= '0;
      eng_n   <= '0;
      base    <= '0;
      issued  <= '0;
      written <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        est[i]    <= E_FREE;
        cyc[i]    <= '0;
        result[i] <= '0;
        tag[i]    <= '0;
      end
    end else begin
      state  <= state_next;
      done   <= finish;
      eng_go <= '0;
      if (start_sweep) begin
        base    <= start;
        issued  <= '0;
        written <= '0;
      end
      if (launch) issued  <= issued + CW'(1);
      if (wr_en)  written <= written + CW'(1);
      for (int i = 0; i < NUM_ENGINES; i++) begin
        case (est[i])
          E_FREE: begin
            if (launch && launch_idx == IW'(i)) begin
              eng_go[i]        <= 1'b1;
              eng_n[32*i +: 32] <= base + 32'(issued);
              tag[i]           <= issued[RAM_ADDR_BITS-1:0];
              cyc[i]           <= '0;
              est[i]           <= E_BUSY;
            end
          end
          E_BUSY: begin
            // cyc equals the cycle index since launch; completion in cycle 0 is not accepted.
            if (cyc[i] != 16'd0 && eng_done[i]) begin
              result[i] <= cyc[i];
              est[i]    <= E_HOLD;
            end else if (cyc[i] != 16'hFFFF) begin
              cyc[i] <= cyc[i] + 16'd1;
            end
          end
          E_HOLD: begin
            if (wr_en && wr_idx == IW'(i)) est[i] <= E_FREE;
          end
          default: est[i] <= E_FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tag[wr_idx]] <= result[wr_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= mem[rd_addr];
  end

`ifdef MAX_TRACK_EN
  always_ff @(posedge clk) begin
    if (reset || start_sweep) begin
      max_count <= '0;
      max_n     <= '0;
    end else if (wr_en && result[wr_idx] > max_count) begin
      max_count <= result[wr_idx];
      max_n     <= base + 32'(tag[wr_idx]);
    end
  end
`endif

endmodule

`default_nettype wire
